// File: rtl/id_decode_pipe_if.sv
// Handshake and decoded-beat bundle for id_decode_pipe.
// The master side feeds instructions and consumes decoded beats; the slave side is the stage itself.
interface id_decode_pipe_if #(
    parameter int LANES = 1
);
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [32*LANES-1:0]    in_inst;
    logic                   out_valid;
    logic                   out_ready;
    logic [3*LANES-1:0]     out_immsel;
    logic [32*LANES-1:0]    out_imm;
    logic [5*LANES-1:0]     out_rs1;
    logic [5*LANES-1:0]     out_rs2;
    logic [5*LANES-1:0]     out_rd;
    logic [LANES-1:0]       out_uses_rs1;
    logic [LANES-1:0]       out_uses_rs2;
    logic [LANES-1:0]       out_writes_rd;
    logic [LANES-1:0]       out_illegal;

    modport master (
        output flush, in_valid, in_inst, out_ready,
        input  in_ready, out_valid, out_immsel, out_imm, out_rs1, out_rs2, out_rd,
               out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_inst, out_ready,
        output in_ready, out_valid, out_immsel, out_imm, out_rs1, out_rs2, out_rd,
               out_uses_rs1, out_uses_rs2, out_writes_rd, out_illegal
    );
endinterface

// File: rtl/id_decode_pipe.sv
// Registered RV32I decode stage (LANES per beat) with a main register plus one skid entry.
// Define ID_DECODE_ILLEGAL_EN to enable illegal-encoding detection on out_illegal.
module id_decode_pipe #(
    parameter int LANES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    id_decode_pipe_if.slave    bus
);
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;

    typedef struct packed {
        logic [2:0]  immsel;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        uses_rs1;
        logic        uses_rs2;
        logic        writes_rd;
        logic        illegal;
    } lane_dec_t;

    typedef lane_dec_t [LANES-1:0] beat_t;

`ifdef ID_DECODE_ILLEGAL_EN
    function automatic logic illegal_lane(input logic [31:0] inst);
        logic [2:0] f3;
        logic [6:0] f7;
        logic       bad;
        f3  = inst[14:12];
        f7  = inst[31:25];
        bad = (inst[1:0] != 2'b11);
        case (inst[6:2])
            OPC_OP: begin
                if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
                    bad = 1'b1;
            end
            OPC_OP_IMM: begin
                if (f3 == 3'd1 && f7 != 7'h00)
                    bad = 1'b1;
                else if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)
                    bad = 1'b1;
            end
            OPC_LOAD:   if (f3 == 3'd3 || f3 >= 3'd6) bad = 1'b1;
            OPC_STORE:  if (f3 >= 3'd3) bad = 1'b1;
            OPC_BRANCH: if (f3 == 3'd2 || f3 == 3'd3) bad = 1'b1;
            OPC_JALR, OPC_JAL, OPC_LUI, OPC_AUIPC: ;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction
`endif

    // Unknown opcodes fall through with an I-format immediate and no register usage.
    function automatic lane_dec_t decode_lane(input logic [31:0] inst);
        lane_dec_t d;
        d           = '0;
        d.rs1       = inst[19:15];
        d.rs2       = inst[24:20];
        d.rd        = inst[11:7];
        d.immsel    = IMM_I;
        d.imm       = {{20{inst[31]}}, inst[31:20]};
        case (inst[6:2])
            OPC_OP: begin
                d.imm       = '0;
                d.uses_rs1  = 1'b1;
                d.uses_rs2  = 1'b1;
                d.writes_rd = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                d.uses_rs1  = 1'b1;
                d.writes_rd = 1'b1;
            end
            OPC_STORE: begin
                d.immsel   = IMM_S;
                d.imm      = {{20{inst[31]}}, inst[31:25], inst[11:7]};
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
            end
            OPC_BRANCH: begin
                d.immsel   = IMM_B;
                d.imm      = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
                d.uses_rs1 = 1'b1;
                d.uses_rs2 = 1'b1;
            end
            OPC_JAL: begin
                d.immsel    = IMM_J;
                d.imm       = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
                d.writes_rd = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                d.immsel    = IMM_U;
                d.imm       = {inst[31:12], 12'b0};
                d.writes_rd = 1'b1;
            end
            default: ;
        endcase
`ifdef ID_DECODE_ILLEGAL_EN
        d.illegal = illegal_lane(inst);
        if (d.illegal)
            d.writes_rd = 1'b0;
`else
        d.illegal = 1'b0;
`endif
        if (inst[11:7] == 5'd0)
            d.writes_rd = 1'b0;
        return d;
    endfunction

    lane_dec_t in_dec [LANES];
    beat_t     in_beat;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_dec
            assign in_dec[gi] = decode_lane(bus.in_inst[32*gi +: 32]);
        end
    endgenerate

    always_comb begin
        in_beat = '0;
        for (int k = 0; k < LANES; k++)
            in_beat[k] = in_dec[k];
    end

    logic  main_valid_q, main_valid_d;
    logic  skid_valid_q, skid_valid_d;
    logic  in_ready_q,   in_ready_d;
    beat_t main_data_q,  main_data_d;
    beat_t skid_data_q,  skid_data_d;
    logic  accept;
    logic  drain;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        accept       = bus.in_valid && in_ready_q;
        drain        = main_valid_q && bus.out_ready;

        if (bus.flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || drain) begin
            // Main frees up: the older skid beat goes first, a new beat refills the skid.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = accept;
                if (accept)
                    skid_data_d = in_beat;
            end else begin
                main_valid_d = accept;
                if (accept)
                    main_data_d = in_beat;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_beat;
        end

        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    logic [3*LANES-1:0]  immsel_o;
    logic [32*LANES-1:0] imm_o;
    logic [5*LANES-1:0]  rs1_o, rs2_o, rd_o;
    logic [LANES-1:0]    uses_rs1_o, uses_rs2_o, writes_rd_o, illegal_o;

    always_comb begin
        immsel_o    = '0;
        imm_o       = '0;
        rs1_o       = '0;
        rs2_o       = '0;
        rd_o        = '0;
        uses_rs1_o  = '0;
        uses_rs2_o  = '0;
        writes_rd_o = '0;
        illegal_o   = '0;
        for (int k = 0; k < LANES; k++) begin
            immsel_o[3*k +: 3]  = main_data_q[k].immsel;
            imm_o[32*k +: 32]   = main_data_q[k].imm;
            rs1_o[5*k +: 5]     = main_data_q[k].rs1;
            rs2_o[5*k +: 5]     = main_data_q[k].rs2;
            rd_o[5*k +: 5]      = main_data_q[k].rd;
            uses_rs1_o[k]       = main_data_q[k].uses_rs1;
            uses_rs2_o[k]       = main_data_q[k].uses_rs2;
            writes_rd_o[k]      = main_data_q[k].writes_rd;
            illegal_o[k]        = main_data_q[k].illegal;
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = main_valid_q;
    assign bus.out_immsel    = immsel_o;
    assign bus.out_imm       = imm_o;
    assign bus.out_rs1       = rs1_o;
    assign bus.out_rs2       = rs2_o;
    assign bus.out_rd        = rd_o;
    assign bus.out_uses_rs1  = uses_rs1_o;
    assign bus.out_uses_rs2  = uses_rs2_o;
    assign bus.out_writes_rd = writes_rd_o;
    assign bus.out_illegal   = illegal_o;
endmodule

// File: tb/tb_id_decode_pipe.sv
// Scoreboard bench for id_decode_pipe: a LANES=1 and a LANES=2 instance driven in lockstep.
module tb_id_decode_pipe;
    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;
    localparam logic [2:0] IMM_J = 3'd4;
`ifdef ID_DECODE_ILLEGAL_EN
    localparam logic ILL0 = 1'b1;
`else
    localparam logic ILL0 = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    id_decode_pipe_if #(.LANES(1)) bus1 ();
    id_decode_pipe_if #(.LANES(2)) bus2 ();

    id_decode_pipe #(.LANES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    id_decode_pipe #(.LANES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        bit          sel_dc;
        logic [31:0] imm;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, wr, ill;
    } vec_t;

    vec_t vt [10];
    int   checks = 0;
    int   errors = 0;
    int   q1 [$];
    int   q2 [$];
    int   waits = 0;

    task automatic set_vec(int i, logic [31:0] inst, logic [2:0] sel, bit dc, logic [31:0] imm,
                           logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                           logic u1, logic u2, logic wr, logic ill);
        vt[i].inst = inst; vt[i].sel = sel; vt[i].sel_dc = dc; vt[i].imm = imm;
        vt[i].rs1 = rs1; vt[i].rs2 = rs2; vt[i].rd = rd;
        vt[i].u1 = u1; vt[i].u2 = u2; vt[i].wr = wr; vt[i].ill = ill;
    endtask

    task automatic cmp_lane(string tag, int vi, logic [2:0] sel, logic [31:0] imm,
                            logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                            logic u1, logic u2, logic wr, logic ill);
        vec_t e;
        e = vt[vi];
        checks++;
        if ((!e.sel_dc && sel !== e.sel) || imm !== e.imm || rs1 !== e.rs1 || rs2 !== e.rs2 ||
            rd !== e.rd || u1 !== e.u1 || u2 !== e.u2 || wr !== e.wr || ill !== e.ill) begin
            errors++;
            $display("FAIL %s vec%0d inst=%h got sel=%0d imm=%h rs1=%0d rs2=%0d rd=%0d u1=%b u2=%b wr=%b ill=%b required sel=%0d imm=%h rs1=%0d rs2=%0d rd=%0d u1=%b u2=%b wr=%b ill=%b",
                     tag, vi, e.inst, sel, imm, rs1, rs2, rd, u1, u2, wr, ill,
                     e.sel, e.imm, e.rs1, e.rs2, e.rd, e.u1, e.u2, e.wr, e.ill);
        end else begin
            $display("ok   %s vec%0d inst=%h imm=%h", tag, vi, e.inst, imm);
        end
    endtask

    task automatic check_val(string name, logic [127:0] act, logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, req);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Monitor: pops the scoreboard on every real transfer and checks hold stability.
    logic [127:0] snap1, snap2;
    logic         hold1 = 1'b0;
    logic         hold2 = 1'b0;
    int           p, a, b;

    always @(negedge clk) begin
        if (hold1 && bus1.out_valid)
            check_val("hold_d1", {bus1.out_immsel, bus1.out_imm, bus1.out_rs1, bus1.out_rs2, bus1.out_rd,
                      bus1.out_uses_rs1, bus1.out_uses_rs2, bus1.out_writes_rd, bus1.out_illegal}, snap1);
        if (hold2 && bus2.out_valid)
            check_val("hold_d2", {bus2.out_immsel, bus2.out_imm, bus2.out_rs1, bus2.out_rs2, bus2.out_rd,
                      bus2.out_uses_rs1, bus2.out_uses_rs2, bus2.out_writes_rd, bus2.out_illegal}, snap2);

        if (rst_n && !bus1.flush && bus1.out_valid && bus1.out_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL d1_unexpected got beat inst-rd=%0d required none", bus1.out_rd);
            end else begin
                p = q1.pop_front();
                cmp_lane("d1", p, bus1.out_immsel, bus1.out_imm, bus1.out_rs1, bus1.out_rs2, bus1.out_rd,
                         bus1.out_uses_rs1[0], bus1.out_uses_rs2[0], bus1.out_writes_rd[0], bus1.out_illegal[0]);
            end
        end
        if (rst_n && !bus2.flush && bus2.out_valid && bus2.out_ready) begin
            if (q2.size() == 0) begin
                checks++; errors++;
                $display("FAIL d2_unexpected got beat rd=%0d required none", bus2.out_rd);
            end else begin
                p = q2.pop_front();
                a = p / 16;
                b = p % 16;
                cmp_lane("d2l0", a, bus2.out_immsel[2:0], bus2.out_imm[31:0], bus2.out_rs1[4:0],
                         bus2.out_rs2[4:0], bus2.out_rd[4:0], bus2.out_uses_rs1[0], bus2.out_uses_rs2[0],
                         bus2.out_writes_rd[0], bus2.out_illegal[0]);
                cmp_lane("d2l1", b, bus2.out_immsel[5:3], bus2.out_imm[63:32], bus2.out_rs1[9:5],
                         bus2.out_rs2[9:5], bus2.out_rd[9:5], bus2.out_uses_rs1[1], bus2.out_uses_rs2[1],
                         bus2.out_writes_rd[1], bus2.out_illegal[1]);
            end
        end

        hold1 = rst_n && !bus1.flush && bus1.out_valid && !bus1.out_ready;
        hold2 = rst_n && !bus2.flush && bus2.out_valid && !bus2.out_ready;
        snap1 = {bus1.out_immsel, bus1.out_imm, bus1.out_rs1, bus1.out_rs2, bus1.out_rd,
                 bus1.out_uses_rs1, bus1.out_uses_rs2, bus1.out_writes_rd, bus1.out_illegal};
        snap2 = {bus2.out_immsel, bus2.out_imm, bus2.out_rs1, bus2.out_rs2, bus2.out_rd,
                 bus2.out_uses_rs1, bus2.out_uses_rs2, bus2.out_writes_rd, bus2.out_illegal};
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(int x, int y);
        bus1.in_inst = vt[x].inst;
        bus2.in_inst = {vt[y].inst, vt[x].inst};
    endtask

    task automatic set_valid(logic v);
        bus1.in_valid = v; bus2.in_valid = v;
    endtask

    task automatic set_ready(logic v);
        bus1.out_ready = v; bus2.out_ready = v;
    endtask

    task automatic set_flush(logic v);
        bus1.flush = v; bus2.flush = v;
    endtask

    task automatic send(int x, int y);
        int n;
        n = 0;
        drive(x, y);
        set_valid(1'b1);
        while (!(bus1.in_ready && bus2.in_ready) && n < 50) begin
            step();
            n++;
            waits++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout got in_ready=%b/%b required 1", bus1.in_ready, bus2.in_ready);
        end else begin
            q1.push_back(x);
            q2.push_back(x * 16 + y);
        end
        step();
        set_valid(1'b0);
    endtask

    task automatic drain_wait();
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL drain_timeout got pending=%0d/%0d required 0", q1.size(), q2.size());
        end
        step();
    endtask

    initial begin
        set_vec(0, 32'hFFF00093, IMM_I, 0, 32'hFFFFFFFF, 5'd0, 5'd31, 5'd1,  1, 0, 1, 0);
        set_vec(1, 32'h0020A423, IMM_S, 0, 32'h00000008, 5'd1, 5'd2,  5'd8,  1, 1, 0, 0);
        set_vec(2, 32'hFE000EE3, IMM_B, 0, 32'hFFFFFFFC, 5'd0, 5'd0,  5'd29, 1, 1, 0, 0);
        set_vec(3, 32'h123452B7, IMM_U, 0, 32'h12345000, 5'd8, 5'd3,  5'd5,  0, 0, 1, 0);
        set_vec(4, 32'h008000EF, IMM_J, 0, 32'h00000008, 5'd0, 5'd8,  5'd1,  0, 0, 1, 0);
        set_vec(5, 32'h002081B3, IMM_I, 1, 32'h00000000, 5'd1, 5'd2,  5'd3,  1, 1, 1, 0);
        set_vec(6, 32'h00001017, IMM_U, 0, 32'h00001000, 5'd0, 5'd0,  5'd0,  0, 0, 0, 0);
        set_vec(7, 32'hFF812283, IMM_I, 0, 32'hFFFFFFF8, 5'd2, 5'd24, 5'd5,  1, 0, 1, 0);
        set_vec(8, 32'h00000000, IMM_I, 0, 32'h00000000, 5'd0, 5'd0,  5'd0,  1, 0, 0, ILL0);
        set_vec(9, 32'h00008067, IMM_I, 0, 32'h00000000, 5'd1, 5'd0,  5'd0,  1, 0, 0, 0);

        set_valid(1'b0); set_ready(1'b0); set_flush(1'b0);
        bus1.in_inst = '0; bus2.in_inst = '0;
        rst_n = 1'b0;
        step(); step(); step();
        check_val("rst_out_valid", {bus1.out_valid, bus2.out_valid}, 128'd0);
        check_val("rst_in_ready", {bus1.in_ready, bus2.in_ready}, 128'd0);
        check_val("rst_outputs", {bus2.out_immsel, bus2.out_imm, bus2.out_rs1, bus2.out_rs2, bus2.out_rd,
                  bus2.out_uses_rs1, bus2.out_uses_rs2, bus2.out_writes_rd, bus2.out_illegal}, 128'd0);
        rst_n = 1'b1;
        step();
        check_val("release_in_ready", {bus1.in_ready, bus2.in_ready}, 128'd3);

        // Full-rate stream, lane pairs chosen to cover every vector in both lanes.
        set_ready(1'b1);
        waits = 0;
        send(3, 0); send(0, 1); send(1, 2); send(2, 4); send(4, 5);
        send(5, 6); send(6, 7); send(7, 8); send(8, 9); send(9, 3);
        check_val("throughput_waits", waits, 128'd0);
        drain_wait();

        // Back-pressure: two beats buffered, in_ready drops, then all five emerge in order.
        set_ready(1'b0);
        send(0, 1);
        send(1, 2);
        check_val("stall_in_ready", {bus1.in_ready, bus2.in_ready}, 128'd0);
        drive(2, 3);
        set_valid(1'b1);
        step();
        set_ready(1'b1);
        send(2, 3); send(3, 4); send(4, 5);
        drain_wait();

        // Flush with skid full and a beat offered in the same cycle.
        set_ready(1'b0);
        send(5, 6);
        send(6, 7);
        drive(7, 8);
        set_valid(1'b1);
        set_flush(1'b1);
        step();
        q1.delete(); q2.delete();
        set_flush(1'b0);
        set_valid(1'b0);
        check_val("flush_out_valid", {bus1.out_valid, bus2.out_valid}, 128'd0);
        check_val("flush_in_ready", {bus1.in_ready, bus2.in_ready}, 128'd3);
        set_ready(1'b1);
        step(); step(); step();
        send(8, 9);
        drain_wait();

        // Reset mid-stream behaves like a flush.
        set_ready(1'b0);
        send(9, 0);
        send(0, 1);
        drive(1, 2);
        set_valid(1'b1);
        rst_n = 1'b0;
        step();
        q1.delete(); q2.delete();
        set_valid(1'b0);
        check_val("mid_rst_out_valid", {bus1.out_valid, bus2.out_valid}, 128'd0);
        check_val("mid_rst_in_ready", {bus1.in_ready, bus2.in_ready}, 128'd0);
        check_val("mid_rst_outputs", {bus2.out_immsel, bus2.out_imm, bus2.out_rs1, bus2.out_rs2, bus2.out_rd,
                  bus2.out_uses_rs1, bus2.out_uses_rs2, bus2.out_writes_rd, bus2.out_illegal}, 128'd0);
        rst_n = 1'b1;
        step();
        check_val("mid_rel_in_ready", {bus1.in_ready, bus2.in_ready}, 128'd3);
        set_ready(1'b1);
        step(); step();
        send(3, 0);
        send(1, 2);
        drain_wait();

        check_val("final_pending", q1.size() + q2.size(), 128'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
